// File: rtl/demux14_pkg.sv
// demux14_pkg: shared definitions for the 1-to-4 sequential lane demux.
//   NUM_LANES          - lanes per assembled word
//   MODE_RR/MODE_ADDR  - fill-mode encodings on the mode input
//   asm_state_t        - assembly FSM state type
//   popcount4          - number of set bits in a 4-bit lane mask
package demux14_pkg;

   localparam int NUM_LANES = 4;

   localparam logic MODE_RR   = 1'b0;
   localparam logic MODE_ADDR = 1'b1;

   typedef enum logic {
      EMPTY,
      FILL
   } asm_state_t;

   function automatic logic [2:0] popcount4(input logic [3:0] m);
      return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
   endfunction

endpackage

// File: rtl/demux14_outbuf.sv
// demux14_outbuf: one-entry output register with a valid/ready handshake.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - a complete word is offered this cycle
//   load_word   - the complete word
//   out_ready   - consumer takes y this cycle
//   y           - held output word
//   out_valid   - y holds a complete word
module demux14_outbuf #(
   parameter int WORD_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WORD_W-1:0] load_word,
   input  logic              out_ready,
   output logic [WORD_W-1:0] y,
   output logic              out_valid
);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         // A new word wins over a drain on the same edge, so the slot
         // stays full and never shows a bubble.
         y         <= load_word;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         // y keeps its last value; only the valid flag drops.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux14_seq.sv
// demux14_seq: collects LANE_W-bit inputs into a 4-lane word and hands it
// to a one-entry output buffer.
//   mode      - 0 round-robin fill, 1 addressed fill (latched at word start)
//   s         - target lane in addressed mode
//   i         - lane data, qualified by in_valid / in_ready
//   flush     - discard the partial word (output buffer untouched)
//   y         - assembled word, lane k at [k*LANE_W +: LANE_W]
//   out_valid - y complete, taken when out_ready is high
//   lane_cnt  - distinct lanes filled in the partial word
module demux14_seq
   import demux14_pkg::*;
#(
   parameter int LANE_W = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          mode,
   input  logic [1:0]                    s,
   input  logic [LANE_W-1:0]             i,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          flush,
   output logic [NUM_LANES*LANE_W-1:0]   y,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2:0]                    lane_cnt
);

   localparam int WORD_W = NUM_LANES * LANE_W;

   asm_state_t        state_q, state_d;
   logic              mode_q, mode_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        mask_q, mask_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [2:0]        cnt_q, cnt_d;

   logic              accept;
   logic              eff_mode;
   logic [1:0]        lane;
   logic [3:0]        mask_n;
   logic [2:0]        cnt_n;
   logic [WORD_W-1:0] word;
   logic              complete;

   // Stall only while a finished word is waiting and not being taken, so a
   // drain and a new accept may share an edge.
   assign in_ready = !flush && !(out_valid && !out_ready);
   assign accept   = in_valid && in_ready;
   assign lane_cnt = cnt_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      state_d  = state_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      mask_d   = mask_q;
      asm_d    = asm_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      mask_n   = mask_q;
      cnt_n    = cnt_q;
      word     = asm_q;

      // Mode is sampled only on the first accept of a word.
      eff_mode = (state_q == EMPTY) ? mode : mode_q;
      lane     = (eff_mode == MODE_ADDR) ? s : idx_q;

      if (flush) begin
         state_d = EMPTY;
         idx_d   = '0;
         mask_d  = '0;
         asm_d   = '0;
         cnt_d   = '0;
      end else if (accept) begin
         mode_d = eff_mode;
         word[int'(lane)*LANE_W +: LANE_W] = i;
         if (eff_mode == MODE_ADDR) begin
            mask_n   = mask_q | (4'b0001 << s);
            cnt_n    = popcount4(mask_n);
            complete = &mask_n;
         end else begin
            cnt_n    = {1'b0, idx_q} + 3'd1;
            complete = (idx_q == 2'd3);
         end

         if (complete) begin
            // Word leaves for the output buffer; restart from all-zero lanes.
            state_d = EMPTY;
            idx_d   = '0;
            mask_d  = '0;
            asm_d   = '0;
            cnt_d   = '0;
         end else begin
            state_d = FILL;
            asm_d   = word;
            mask_d  = mask_n;
            cnt_d   = cnt_n;
            if (eff_mode == MODE_RR) idx_d = idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         mode_q  <= MODE_RR;
         idx_q   <= '0;
         mask_q  <= '0;
         asm_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         asm_q   <= asm_d;
         cnt_q   <= cnt_d;
      end
   end

   demux14_outbuf #(
      .WORD_W (WORD_W)
   ) u_outbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (complete),
      .load_word (word),
      .out_ready (out_ready),
      .y         (y),
      .out_valid (out_valid)
   );

endmodule

// File: doc/demux14_seq.md
DEMUX14_SEQ -- requirements
Module: demux14_seq

Interface
REQ-001 SHALL have parameter LANE_W, default 1, bits carried per lane.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port mode  input  1  0 = round-robin lane fill, 1 = addressed lane fill.
REQ-005 SHALL have port s  input  2  target lane index, used only in addressed mode.
REQ-006 SHALL have port i  input  LANE_W  input lane data.
REQ-007 SHALL have port in_valid  input  1  i (and s) valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts i this cycle.
REQ-009 SHALL have port flush  input  1  synchronous discard of the partial word.
REQ-010 SHALL have port y  output  4*LANE_W  assembled word; lane k occupies bits [k*LANE_W +: LANE_W].
REQ-011 SHALL have port out_valid  output  1  y holds a complete word.
REQ-012 SHALL have port out_ready  input  1  consumer takes y this cycle.
REQ-013 SHALL have port lane_cnt  output  3  number of distinct lanes filled in the partial word, 0..4.

Function
REQ-014 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready.
REQ-015 SHALL drive in_ready = !flush & !(out_valid & !out_ready).
REQ-016 SHALL use assembly FSM states EMPTY (lane_cnt = 0) and FILL (lane_cnt 1..3); on completion the word moves to the output buffer and the FSM returns to EMPTY on the same edge.
REQ-017 SHALL latch mode only on an accept in EMPTY; mode changes during FILL are ignored until the next EMPTY.
REQ-018 Round-robin: SHALL write i to lane idx, with idx starting at 0 and incrementing by 1 per accept; completion on the accept at idx = 3; idx wraps to 0.
REQ-019 Addressed: SHALL write i to lane s and set lane_mask[s]; a rewrite of an already-set lane SHALL overwrite the data and leave lane_cnt unchanged; completion when lane_mask = 4'b1111.
REQ-020 SHALL assert out_valid on the clock edge after the completing accept, with y equal to the assembled lanes; latency is 1 cycle.
REQ-021 SHALL hold y and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL clear out_valid on drain unless a new word completes on the same edge, in which case y loads the new word and out_valid stays 1.
REQ-023 flush SHALL clear idx, lane_mask and lane_cnt to EMPTY; in_ready is 0 that cycle, so no input is lost silently; flush SHALL NOT affect y or out_valid.
REQ-024 Unfilled lanes in an assembly SHALL read as zero, so each new word starts from an all-zero assembly register.
REQ-025 lane_cnt SHALL be registered and SHALL equal idx in round-robin mode and popcount(lane_mask) in addressed mode.

Reset
REQ-026 While rst_n = 0, the block SHALL force y = 0, out_valid = 0, lane_cnt = 0, idx = 0, lane_mask = 0, latched mode = 0 and FSM = EMPTY, asynchronously.
REQ-027 A reset asserted mid-word SHALL discard the partial word and any unconsumed output word.
REQ-028 After deassertion, the first accept SHALL be possible on the first rising edge.

Structure
REQ-029 Package demux14_pkg SHALL hold NUM_LANES = 4, the mode encodings MODE_RR = 1'b0 and MODE_ADDR = 1'b1, and the FSM state type {EMPTY, FILL}.
REQ-030 A single sub-module, demux14_outbuf, SHALL implement the one-entry output register with its valid/ready handshake (REQ-020..022).
REQ-031 The assembly register, idx and lane_mask SHALL stay in demux14_seq.

Verification
REQ-032 RR basic: LANE_W = 1, mode = 0, out_ready = 1, i = 1,0,1,1 on 4 consecutive cycles -> one cycle later y = 4'b1101, out_valid = 1 for 1 cycle, lane_cnt sequence 1,2,3,0.
REQ-033 Addressed with rewrite: mode = 1, (s,i) = (2,1),(0,1),(2,0),(3,1),(1,0) -> lane_cnt 1,2,2,3,0 and y = 4'b1001.
REQ-034 Backpressure: out_ready = 0 after a complete word 4'b1010 -> in_ready = 0, y holds 4'b1010; raise out_ready while the next word's 4th input is presented -> new word loads and out_valid stays 1.
REQ-035 Flush: in RR mode after 2 accepts (lane_cnt = 2), assert flush for 1 cycle with in_valid = 1 -> in_ready = 0, lane_cnt = 0; the next 4 inputs 0,1,1,0 yield y = 4'b0110.
REQ-036 Mode change mid-word: switch mode 0->1 after 1 accept -> the word completes in round-robin order; the next word uses addressed mode.
REQ-037 Async reset: drop rst_n between clock edges with out_valid = 1 and lane_cnt = 3 -> all outputs are 0 immediately, and the first post-reset word assembles from lane 0.
